ioports_host: RTL and testbench

Host-side initiator for the 8-bit command/byte-stream protocol served by the general-purpose I/O port block. It accepts one word-level request at a time (reset ports, write a 32-bit output port, read a 32-bit input port) and serializes it into `load`/`datain` byte pulses. For reads, it collects the four returned bytes through the `ready`/`enout` handshake. It sits between an on-chip controller or testbench driver and the I/O port block, and connects to the I/O port block by identical port names.

---
 rtl/ioports_pkg.sv | 49 ++++
 rtl/ioports_host_timer.sv | 27 ++
 rtl/ioports_host.sv | 182 ++++++++++++++++++
 tb/tb_ioports_host.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioports_pkg.sv
// Shared definitions for the I/O port host initiator: command codes, request codes,
// FSM state encoding and byte-selection helpers.
package ioports_pkg;

    localparam logic [2:0] CMD_RESET = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b010;
    localparam logic [2:0] CMD_READ  = 3'b011;

    localparam logic [1:0] REQ_ILLEGAL = 2'b00;
    localparam logic [1:0] REQ_RESET   = 2'b01;
    localparam logic [1:0] REQ_WRITE   = 2'b10;
    localparam logic [1:0] REQ_READ    = 2'b11;

    localparam logic [3:0] HW_ID_ADDR = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWait,
        StRdReq,
        StRdRel,
        StDone
    } host_state_e;

    function automatic logic [7:0] cmd_byte(input logic [1:0] req, input logic [3:0] addr);
        logic [2:0] code;
        case (req)
            REQ_RESET: code = CMD_RESET;
            REQ_WRITE: code = CMD_WRITE;
            REQ_READ:  code = CMD_READ;
            default:   code = 3'b000;
        endcase
        return {1'b0, code, addr};
    endfunction

    // idx 0 is the command byte, 1..4 walk the write data MSB first.
    function automatic logic [7:0] byte_sel(input logic [7:0] cmd, input logic [31:0] wdata,
                                            input logic [2:0] idx);
        case (idx)
            3'd0:    return cmd;
            3'd1:    return wdata[31:24];
            3'd2:    return wdata[23:16];
            3'd3:    return wdata[15:8];
            3'd4:    return wdata[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ioports_host_timer.sv
// Loadable down-counter that saturates at zero; shared by the inter-byte gap
// and the read-handshake timeout.
module ioports_host_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    output logic             zero
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/ioports_host.sv
// Host-side initiator: serializes word-level reset/write/read requests into the
// load/datain byte stream and collects read bytes over the ready/enout handshake.
module ioports_host
    import ioports_pkg::*;
#(
    parameter int unsigned GAP     = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cmd,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        load,
    output logic [7:0]  datain,
    output logic        ready,
    input  logic        enout,
    input  logic [7:0]  dataout
);

    localparam int unsigned TmrMax = (GAP > TIMEOUT) ? GAP : TIMEOUT;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    host_state_e state_q;
    logic [1:0]  cmd_q;
    logic [3:0]  addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  idx_q;
    logic [1:0]  rd_idx_q;
    logic [31:0] rdata_q;

    logic            req_ready_q, rsp_valid_q, rsp_err_q, load_q, ready_q;
    logic [31:0]     rsp_rdata_q;
    logic [7:0]      datain_q;
    logic            tmr_load, tmr_zero;
    logic [TmrW-1:0] tmr_value;

    // Counter runs GAP cycles in WAIT and TIMEOUT cycles in each handshake phase,
    // so it is loaded with one less than the desired cycle count.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = TmrW'(TIMEOUT - 1);
        case (state_q)
            StSend: begin
                tmr_load  = 1'b1;
                tmr_value = TmrW'(GAP - 1);
            end
            StWait:  tmr_load = tmr_zero && (cmd_q == REQ_READ);
            StRdReq: tmr_load = enout;
            StRdRel: tmr_load = !enout && (rd_idx_q != 2'd3);
            default: tmr_load = 1'b0;
        endcase
    end

    ioports_host_timer #(
        .Width(TmrW)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (tmr_load),
        .load_value(tmr_value),
        .zero      (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cmd_q       <= 2'b00;
            addr_q      <= 4'h0;
            wdata_q     <= 32'h0;
            idx_q       <= 3'd0;
            rd_idx_q    <= 2'd0;
            rdata_q     <= 32'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            load_q      <= 1'b0;
            datain_q    <= 8'h00;
            ready_q     <= 1'b0;
        end else begin
            load_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        cmd_q       <= req_cmd;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        idx_q       <= 3'd0;
                        rd_idx_q    <= 2'd0;
                        rdata_q     <= 32'h0;
                        req_ready_q <= 1'b0;
                        if (req_cmd == REQ_ILLEGAL) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                            state_q     <= StDone;
                        end else begin
                            load_q   <= 1'b1;
                            datain_q <= cmd_byte(req_cmd, req_addr);
                            state_q  <= StSend;
                        end
                    end
                end
                StSend: state_q <= StWait;
                StWait: begin
                    if (tmr_zero) begin
                        if (cmd_q == REQ_WRITE && idx_q != 3'd4) begin
                            idx_q    <= idx_q + 3'd1;
                            load_q   <= 1'b1;
                            datain_q <= byte_sel(cmd_byte(cmd_q, addr_q), wdata_q, idx_q + 3'd1);
                            state_q  <= StSend;
                        end else if (cmd_q == REQ_READ) begin
                            ready_q <= 1'b1;
                            state_q <= StRdReq;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= 32'h0;
                            state_q     <= StDone;
                        end
                    end
                end
                StRdReq: begin
                    if (enout) begin
                        // First byte shifts up to [31:24] after four captures.
                        rdata_q <= {rdata_q[23:0], dataout};
                        ready_q <= 1'b0;
                        state_q <= StRdRel;
                    end else if (tmr_zero) begin
                        ready_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 32'h0;
                        state_q     <= StDone;
                    end
                end
                StRdRel: begin
                    if (!enout) begin
                        if (rd_idx_q == 2'd3) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= rdata_q;
                            state_q     <= StDone;
                        end else begin
                            rd_idx_q <= rd_idx_q + 2'd1;
                            ready_q  <= 1'b1;
                            state_q  <= StRdReq;
                        end
                    end else if (tmr_zero) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 32'h0;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    req_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign load      = load_q;
    assign datain    = datain_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_ioports_host.sv
// Directed bench for ioports_host with a behavioural I/O port block model that
// decodes the byte stream and answers reads over the ready/enout handshake.
module tb_ioports_host;

    localparam int unsigned GAP     = 4;
    localparam int unsigned TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_cmd = 2'b00;
    logic [3:0]  req_addr = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        load;
    logic [7:0]  datain;
    logic        ready;
    logic        enout = 1'b0;
    logic [7:0]  dataout = 8'h00;

    ioports_host #(
        .GAP    (GAP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cmd  (req_cmd),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_err  (rsp_err),
        .rsp_rdata(rsp_rdata),
        .load     (load),
        .datain   (datain),
        .ready    (ready),
        .enout    (enout),
        .dataout  (dataout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_acc = 0;

    int         load_off[$];
    logic [7:0] load_byte[$];
    bit          rsp_seen = 0;
    int          rsp_off = 0;
    logic        rsp_err_s = 1'b0;
    logic [31:0] rsp_rdata_s = 32'h0;
    int          enout_rises = 0;
    int          viol = 0;
    logic        prev_ready = 1'b0;

    logic [31:0] dev_out[16];
    logic [31:0] dev_in[16];
    int          dev_idx = 0;
    logic [2:0]  dev_cmd = 3'b000;
    logic [3:0]  dev_addr = 4'h0;
    logic [31:0] dev_sh = 32'h0;
    logic [31:0] dev_tmp;
    bit          reading = 0;
    bit          stuck = 0;
    int          rd_k = 0;
    int          outf_pulse = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor plus I/O port block model, all evaluated away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            enout   = 1'b0;
            reading = 0;
            dev_idx = 0;
            rd_k    = 0;
            prev_ready = 1'b0;
            for (int i = 0; i < 16; i++) dev_out[i] = 32'h0;
        end else begin
            if (load) begin
                load_off.push_back(cyc - t_acc);
                load_byte.push_back(datain);
                if (dev_idx == 0) begin
                    dev_cmd  = datain[6:4];
                    dev_addr = datain[3:0];
                    case (dev_cmd)
                        3'b001: for (int i = 0; i < 15; i++) dev_out[i] = 32'h0;
                        3'b010: dev_idx = 1;
                        3'b011: begin
                            reading = 1;
                            rd_k    = 0;
                        end
                        default: ;
                    endcase
                end else begin
                    dev_sh = {dev_sh[23:0], datain};
                    if (dev_idx == 4) begin
                        dev_out[dev_addr] = dev_sh;
                        dev_idx = 0;
                        if (dev_addr == 4'hF) outf_pulse++;
                    end else begin
                        dev_idx++;
                    end
                end
            end
            if (rsp_valid && !rsp_seen) begin
                rsp_seen    = 1;
                rsp_off     = cyc - t_acc;
                rsp_err_s   = rsp_err;
                rsp_rdata_s = rsp_rdata;
            end
            if (ready && !prev_ready && enout) viol++;
            prev_ready = ready;
            if (reading && !stuck) begin
                if (ready && !enout && rd_k < 4) begin
                    dev_tmp = dev_in[dev_addr];
                    dataout = dev_tmp[31-8*rd_k -: 8];
                    enout   = 1'b1;
                    enout_rises++;
                end else if (!ready && enout) begin
                    enout = 1'b0;
                    rd_k++;
                    if (rd_k == 4) reading = 0;
                end
            end
        end
    end

    task automatic send_req(input logic [1:0] cmd, input logic [3:0] addr,
                            input logic [31:0] wdata);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        load_off.delete();
        load_byte.delete();
        rsp_seen    = 0;
        enout_rises = 0;
        viol        = 0;
        t_acc       = cyc;
        req_cmd     = cmd;
        req_addr    = addr;
        req_wdata   = wdata;
        req_valid   = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        for (int i = 0; i < budget && !rsp_seen; i++) @(negedge clk);
        if (!rsp_seen) chk("rsp_wait_expired", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    int         exp_off[5] = '{1, 6, 11, 16, 21};
    logic [7:0] exp_b[5] = '{8'h23, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    initial begin
        for (int i = 0; i < 16; i++) dev_in[i] = 32'h0;
        dev_in[2] = 32'h12345678;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_load", {31'h0, load}, 32'd0);
        chk("rst_ready", {31'h0, ready}, 32'd0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_datain", {24'h0, datain}, 32'h0);
        reset = 1'b0;

        // Write 0xDEADBEEF to port 3.
        send_req(2'b10, 4'd3, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_req_ready_fall", {31'h0, req_ready}, 32'd0);
        wait_rsp(100);
        chk("wr_load_count", load_off.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wr_load_off%0d", i), load_off[i], exp_off[i]);
            chk($sformatf("wr_byte%0d", i), {24'h0, load_byte[i]}, {24'h0, exp_b[i]});
        end
        chk("wr_rsp_off", rsp_off, 32'd26);
        chk("wr_rsp_err", {31'h0, rsp_err_s}, 32'd0);
        chk("wr_out3", dev_out[3], 32'hDEADBEEF);
        chk("wr_req_ready_back", {31'h0, req_ready}, 32'd1);

        // Write port 15 then immediately port 0.
        send_req(2'b10, 4'hF, 32'h1);
        wait_rsp(100);
        chk("wrf_cmd_byte", {24'h0, load_byte[0]}, 32'h2F);
        chk("wrf_pulse", outf_pulse, 32'd1);
        send_req(2'b10, 4'h0, 32'h55);
        wait_rsp(100);
        chk("wr0_out0", dev_out[0], 32'h55);
        chk("wr0_rsp_off", rsp_off, 32'd26);

        // Read port 2.
        send_req(2'b11, 4'd2, 32'h0);
        wait_rsp(300);
        chk("rd_cmd_byte", {24'h0, load_byte[0]}, 32'h32);
        chk("rd_load_count", load_off.size(), 32'd1);
        chk("rd_rdata", rsp_rdata_s, 32'h12345678);
        chk("rd_err", {31'h0, rsp_err_s}, 32'd0);
        chk("rd_enout_pulses", enout_rises, 32'd4);
        chk("rd_ready_overlap", viol, 32'd0);
        chk("rd_ready_after", {31'h0, ready}, 32'd0);

        // Fill ports 0..14, then issue a port reset.
        for (int i = 0; i < 15; i++) begin
            send_req(2'b10, 4'(i), 32'hA0 + i);
            wait_rsp(100);
        end
        chk("fill_out14", dev_out[14], 32'hAE);
        send_req(2'b01, 4'h0, 32'h0);
        wait_rsp(50);
        chk("rst_cmd_byte", {24'h0, load_byte[0]}, 32'h10);
        chk("rst_rsp_off", rsp_off, 32'd6);
        chk("rst_rsp_err_req", {31'h0, rsp_err_s}, 32'd0);
        chk("rst_out0", dev_out[0], 32'h0);
        chk("rst_out14", dev_out[14], 32'h0);

        // Illegal command.
        send_req(2'b00, 4'h5, 32'h0);
        wait_rsp(20);
        chk("ill_rsp_off", rsp_off, 32'd1);
        chk("ill_err", {31'h0, rsp_err_s}, 32'd1);
        chk("ill_no_loads", load_off.size(), 32'd0);

        // Read against a stuck-low enout.
        stuck = 1;
        send_req(2'b11, 4'd2, 32'h0);
        wait_rsp(400);
        chk("to_rsp_off", rsp_off, 32'd261);
        chk("to_err", {31'h0, rsp_err_s}, 32'd1);
        chk("to_rdata", rsp_rdata_s, 32'h0);
        chk("to_ready_after", {31'h0, ready}, 32'd0);
        stuck = 0;

        // Asynchronous reset in the middle of a read, then a clean write.
        send_req(2'b11, 4'd2, 32'h0);
        begin
            int guard = 0;
            while (!(rd_k == 2 && ready) && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            chk("mid_reached_byte2", {31'h0, (rd_k == 2 && ready)}, 32'd1);
        end
        #1 reset = 1'b1;
        #1;
        chk("mid_ready", {31'h0, ready}, 32'd0);
        chk("mid_load", {31'h0, load}, 32'd0);
        chk("mid_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("mid_req_ready", {31'h0, req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        send_req(2'b10, 4'd1, 32'hCAFE0001);
        wait_rsp(100);
        chk("post_out1", dev_out[1], 32'hCAFE0001);
        chk("post_rsp_off", rsp_off, 32'd26);
        chk("post_err", {31'h0, rsp_err_s}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1);
    end

endmodule
